// File: rtl/pe_route_pkg.sv
// Shared PE routing definitions: destination count and the select-to-destination decode.
// The operand select mux and the token distributor both use this decode.
package pe_route_pkg;

   localparam int unsigned NUM_DEST = 12;
   localparam int unsigned SEL_W    = 4;

   // Selects 0-7 index the packed bus; 8-10 map directly; 11-15 all land on 11.
   function automatic logic [SEL_W-1:0] sel_to_dest(input logic [SEL_W-1:0] sel);
      logic [SEL_W-1:0] dest;
      if (!sel[3]) begin
         dest = {1'b0, sel[2:0]};
      end else if (sel <= 4'd10) begin
         dest = sel;
      end else begin
         dest = 4'd11;
      end
      return dest;
   endfunction

endpackage

// File: rtl/demux12_slot.sv
// One-entry token register for a single destination.
// A write in the same cycle as a drain replaces the held token without a bubble.
module demux12_slot #(
   parameter int unsigned DATA_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [DATA_SIZE-1:0] wr_data,
   input  logic                 rd_ready,
   output logic                 full,
   output logic [DATA_SIZE-1:0] data
);

   logic                 full_q;
   logic [DATA_SIZE-1:0] data_q;

   // Data is held (not cleared) on drain; only full drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else if (wr_en) begin
         full_q <= 1'b1;
         data_q <= wr_data;
      end else if (full_q && rd_ready) begin
         full_q <= 1'b0;
      end
   end

   assign full = full_q;
   assign data = data_q;

endmodule

// File: rtl/demux12_buf.sv
// Buffered 1-to-12 token distributor: decodes the select, gates acceptance on the
// chosen slot only (head-of-line blocking is intended) and packs the slot outputs.
module demux12_buf
   import pe_route_pkg::*;
#(
   parameter int unsigned DATA_SIZE = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_SIZE-1:0]          in_data,
   input  logic [SEL_W-1:0]              in_sel,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [7:0][DATA_SIZE-1:0]     out0_7,
   output logic [DATA_SIZE-1:0]          out8,
   output logic [DATA_SIZE-1:0]          out9,
   output logic [DATA_SIZE-1:0]          out10,
   output logic [DATA_SIZE-1:0]          out11,
   output logic [NUM_DEST-1:0]           out_valid,
   input  logic [NUM_DEST-1:0]           out_ready
);

   logic [SEL_W-1:0]     dest;
   logic [NUM_DEST-1:0]  wr_en;
   logic [NUM_DEST-1:0]  full;
   logic [DATA_SIZE-1:0] slot_data [NUM_DEST];

   assign dest     = sel_to_dest(in_sel);
   assign in_ready = !full[dest] || out_ready[dest];

   always_comb begin
      wr_en = '0;
      if (in_valid && in_ready) begin
         wr_en[dest] = 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_DEST; i++) begin : g_slot
      demux12_slot #(
         .DATA_SIZE (DATA_SIZE)
      ) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .wr_en    (wr_en[i]),
         .wr_data  (in_data),
         .rd_ready (out_ready[i]),
         .full     (full[i]),
         .data     (slot_data[i])
      );
   end

   for (genvar i = 0; i < 8; i++) begin : g_pack
      assign out0_7[i] = slot_data[i];
   end

   assign out8      = slot_data[8];
   assign out9      = slot_data[9];
   assign out10     = slot_data[10];
   assign out11     = slot_data[11];
   assign out_valid = full;

endmodule

// File: tb/tb_demux12_buf.sv
// Self-checking bench for demux12_buf: directed scenarios plus randomized traffic,
// all compared against a slot-array reference model.
module tb_demux12_buf;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [7:0]      in_data = '0;
   logic [3:0]      in_sel = '0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [7:0][7:0] out0_7;
   logic [7:0]      out8, out9, out10, out11;
   logic [11:0]     out_valid;
   logic [11:0]     out_ready = '0;

   int n_tests = 0;
   int n_fail  = 0;

   bit       m_full [12];
   bit [7:0] m_data [12];

   demux12_buf #(
      .DATA_SIZE (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out0_7    (out0_7),
      .out8      (out8),
      .out9      (out9),
      .out10     (out10),
      .out11     (out11),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int dest_of(input int sel);
      return (sel > 11) ? 11 : sel;
   endfunction

   function automatic logic [7:0] dut_slot(input int i);
      if (i < 8) return out0_7[i];
      if (i == 8) return out8;
      if (i == 9) return out9;
      if (i == 10) return out10;
      return out11;
   endfunction

   function automatic logic [11:0] model_valid();
      logic [11:0] v = '0;
      for (int i = 0; i < 12; i++) v[i] = m_full[i];
      return v;
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, ".out_valid"}, {20'h0, out_valid}, {20'h0, model_valid()});
      for (int i = 0; i < 12; i++)
         check($sformatf("%s.data%0d", tag, i), {24'h0, dut_slot(i)}, {24'h0, m_data[i]});
   endtask

   task automatic model_reset();
      for (int i = 0; i < 12; i++) begin
         m_full[i] = 1'b0;
         m_data[i] = 8'h00;
      end
   endtask

   // Inputs are set by the caller just after a rising edge; this checks in_ready,
   // clocks once, advances the model and checks every output.
   task automatic cycle(input string tag, output bit acc);
      int  d;
      bit  exp_ready;
      #1;
      d = dest_of(int'(in_sel));
      exp_ready = !m_full[d] || out_ready[d];
      check({tag, ".in_ready"}, {31'h0, in_ready}, {31'h0, exp_ready});
      acc = in_valid && exp_ready;
      @(posedge clk);
      for (int i = 0; i < 12; i++) begin
         if (acc && i == d) begin
            m_full[i] = 1'b1;
            m_data[i] = in_data;
         end else if (m_full[i] && out_ready[i]) begin
            m_full[i] = 1'b0;
         end
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic drive(input bit v, input int sel, input logic [7:0] data,
                        input logic [11:0] ordy);
      in_valid  = v;
      in_sel    = sel[3:0];
      in_data   = data;
      out_ready = ordy;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      bit hold;
      model_reset();

      // Reset state
      #12;
      check("rst.in_ready", {31'h0, in_ready}, 32'h1);
      check_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Mid-stream reset with slots 3 and 9 full
      drive(1, 3, 8'h33, 12'h000); cycle("pre3", acc);
      drive(1, 9, 8'h99, 12'h000); cycle("pre9", acc);
      check("pre.valid", {20'h0, out_valid}, 32'h208);
      drive(0, 0, 8'h00, 12'h000);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("mrst.out_valid", {20'h0, out_valid}, 32'h0);
      check("mrst.d3", {24'h0, out0_7[3]}, 32'h0);
      check("mrst.d9", {24'h0, out9}, 32'h0);
      check("mrst.in_ready", {31'h0, in_ready}, 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst.in_ready", {31'h0, in_ready}, 32'h1);

      // Basic routing over every select value
      for (int s = 0; s < 16; s++) begin
         drive(1, s, 8'h10 + 8'(s), 12'h000);
         cycle($sformatf("route%0d", s), acc);
         check($sformatf("route%0d.onehot", s), {20'h0, out_valid},
               32'h1 << dest_of(s));
         drive(0, 0, 8'h00, 12'hFFF);
         cycle($sformatf("drain%0d", s), acc);
      end

      // Back-pressure on slot 5
      drive(1, 5, 8'hA5, 12'h000); cycle("bp_fill", acc);
      drive(1, 5, 8'h5A, 12'h000); cycle("bp_block", acc);
      check("bp_block.acc", {31'h0, acc}, 32'h0);
      check("bp_block.hold", {24'h0, out0_7[5]}, 32'hA5);
      drive(1, 5, 8'h5A, 12'h020); cycle("bp_release", acc);
      check("bp_release.acc", {31'h0, acc}, 32'h1);
      check("bp_release.data", {24'h0, out0_7[5]}, 32'h5A);
      check("bp_release.valid", {31'h0, out_valid[5]}, 32'h1);
      drive(0, 0, 8'h00, 12'hFFF); cycle("bp_drain", acc);

      // Streaming into slot 10
      for (int k = 0; k < 16; k++) begin
         drive(1, 10, 8'h30 + 8'(k), 12'h400);
         cycle($sformatf("stream%0d", k), acc);
         check($sformatf("stream%0d.acc", k), {31'h0, acc}, 32'h1);
         check($sformatf("stream%0d.out10", k), {24'h0, out10}, 32'h30 + k);
      end
      drive(0, 0, 8'h00, 12'hFFF); cycle("stream_drain", acc);

      // Head-of-line blocking: sel 2 stalled, sel 7 waits behind it
      drive(1, 2, 8'h12, 12'h000); cycle("hol_fill", acc);
      for (int k = 0; k < 3; k++) begin
         drive(1, 2, 8'h22, 12'h000);
         cycle($sformatf("hol_stall%0d", k), acc);
         check($sformatf("hol_stall%0d.acc", k), {31'h0, acc}, 32'h0);
         check($sformatf("hol_stall%0d.v7", k), {31'h0, out_valid[7]}, 32'h0);
      end
      drive(1, 2, 8'h22, 12'h004); cycle("hol_go", acc);
      check("hol_go.acc", {31'h0, acc}, 32'h1);
      check("hol_go.v7", {31'h0, out_valid[7]}, 32'h0);
      drive(1, 7, 8'h77, 12'h000); cycle("hol_sel7", acc);
      drive(0, 0, 8'h00, 12'hFFF); cycle("hol_drain", acc);

      // Parallel drain of slots 0, 8, 11
      drive(1, 0, 8'hC0, 12'h000); cycle("par0", acc);
      drive(1, 8, 8'hC8, 12'h000); cycle("par8", acc);
      drive(1, 11, 8'hCB, 12'h000); cycle("par11", acc);
      check("par.valid", {20'h0, out_valid}, 32'h901);
      drive(0, 0, 8'h00, 12'hFFF); cycle("par_drain", acc);
      check("par_drain.valid", {20'h0, out_valid}, 32'h0);
      check("par_drain.d8", {24'h0, out8}, 32'hC8);
      check("par_drain.d11", {24'h0, out11}, 32'hCB);

      // Randomized traffic; a blocked token is held stable until accepted
      hold = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (!hold) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = 4'($urandom_range(0, 15));
            in_data  = 8'($urandom);
         end
         out_ready = 12'($urandom);
         cycle($sformatf("rnd%0d", k), acc);
         hold = in_valid && !acc;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
